// File: rtl/frame_pkg.sv
// Shared definitions for the frame byte serializer slice: default frame
// geometry, the serializer state encoding, the pixel type and the colour-bar
// helper used by the optional test pattern generator (TEST_PATTERN_EN).
package frame_pkg;

  localparam int H_PIXELS_DEF = 110;
  localparam int V_LINES_DEF  = 110;
  localparam int CW_DEF       = 10;

  typedef enum logic [1:0] {IDLE, B0, B1, B2} ser_state_t;

  typedef logic [23:0] rgb24_t;

  // Expand a 3-bit bar index into {B,G,R}, each channel fully on or off
  function automatic rgb24_t bar_colour(input logic [2:0] bar);
    return {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
  endfunction

endpackage

// File: rtl/frame_pos_counter.sv
// Raster position tracker for the serializer. Holds the position the next
// loaded pixel will take, latches the coordinates of the pixel currently being
// serialized, forces start-of-frame pixels to the origin and flags frame
// completion and misplaced start-of-frame markers.
// With TEST_PATTERN_EN defined, the upcoming column is exported for the
// test pattern generator.
module frame_pos_counter
  import frame_pkg::*;
#(
  parameter int H_PIXELS = H_PIXELS_DEF,
  parameter int V_LINES  = V_LINES_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          sof,
  input  logic          last_byte,
  output logic [CW-1:0] px_out,
  output logic [CW-1:0] line_out,
`ifdef TEST_PATTERN_EN
  output logic [CW-1:0] next_px,
`endif
  output logic          frame_done,
  output logic          sof_err
);

  logic [CW-1:0] pos_px;
  logic [CW-1:0] pos_line;
  logic [CW-1:0] cur_px;
  logic [CW-1:0] cur_line;
  logic          pos_at_origin;

  // Coordinate the loading pixel will take; a start-of-frame marker forces the origin
  always_comb begin
    pos_at_origin = (pos_px == '0) && (pos_line == '0);
    cur_px        = sof ? '0 : pos_px;
    cur_line      = sof ? '0 : pos_line;
  end

  // Latch the loaded pixel's coordinates and step the raster position past it
  always_ff @(posedge clk) begin
    if (reset) begin
      px_out   <= '0;
      line_out <= '0;
      pos_px   <= '0;
      pos_line <= '0;
    end else if (load) begin
      px_out   <= cur_px;
      line_out <= cur_line;
      if (cur_px == CW'(H_PIXELS - 1)) begin
        pos_px   <= '0;
        pos_line <= (cur_line == CW'(V_LINES - 1)) ? '0 : cur_line + CW'(1);
      end else begin
        pos_px   <= cur_px + CW'(1);
        pos_line <= cur_line;
      end
    end
  end

  // Registered so the error lands in the first byte cycle of the forced pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      sof_err <= 1'b0;
    end else begin
      sof_err <= load && sof && !pos_at_origin;
    end
  end

  // Frame is complete while the last byte of the bottom-right pixel is on the bus
  always_comb begin
    frame_done = last_byte && (px_out == CW'(H_PIXELS - 1)) &&
                 (line_out == CW'(V_LINES - 1));
  end

`ifdef TEST_PATTERN_EN
  assign next_px = pos_px;
`endif

endmodule

// File: rtl/frame_byte_serializer.sv
// Frame byte serializer: accepts 24-bit RGB pixels on a valid/ready handshake
// and emits each as three bytes (R, G, B) with coordinates for the
// frame-buffer writer. Back-to-back pixels stream one byte per cycle.
// Optional feature macro TEST_PATTERN_EN adds a test_mode input which replaces
// the input stream with self-generated 8 vertical colour bars.
module frame_byte_serializer
  import frame_pkg::*;
#(
  parameter int H_PIXELS = H_PIXELS_DEF,
  parameter int V_LINES  = V_LINES_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_valid,
  output logic          pix_ready,
  input  logic [23:0]   pix_data,
  input  logic          pix_sof,
  output logic [7:0]    byte_out,
  output logic          byte_valid,
  output logic [CW-1:0] px_out,
  output logic [CW-1:0] line_out,
  output logic          frame_done,
  output logic          sof_err
`ifdef TEST_PATTERN_EN
  ,
  input  logic          test_mode
`endif
);

  ser_state_t state;
  ser_state_t state_next;
  rgb24_t     data_reg;
  rgb24_t     load_data;
  logic       accept;
  logic       load;
  logic       load_sof;

`ifdef TEST_PATTERN_EN
  logic [CW-1:0] next_px;
  logic [2:0]    bar_idx;
  logic          gen_load;
`endif

  // Decide whether a pixel enters the serializer this cycle and from where
  always_comb begin
    accept   = pix_valid && pix_ready;
    load_sof = accept && pix_sof;
`ifdef TEST_PATTERN_EN
    bar_idx   = 3'(({next_px, 3'b000}) / (CW + 3)'(H_PIXELS));
    gen_load  = test_mode && ((state == IDLE) || (state == B2));
    load      = accept || gen_load;
    load_data = gen_load ? bar_colour(bar_idx) : pix_data;
`else
    load      = accept;
    load_data = pix_data;
`endif
  end

  // Capture the pixel being serialized
  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg <= '0;
    end else if (load) begin
      data_reg <= load_data;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Byte sequencing: three byte cycles per pixel, chaining straight into the next
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = load ? B0 : IDLE;
      B0:      state_next = B1;
      B1:      state_next = B2;
      B2:      state_next = load ? B0 : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake and byte mux, low byte first
  always_comb begin
    pix_ready  = 1'b0;
    byte_valid = 1'b0;
    byte_out   = '0;
    case (state)
      IDLE: pix_ready = 1'b1;
      B0: begin
        byte_valid = 1'b1;
        byte_out   = data_reg[7:0];
      end
      B1: begin
        byte_valid = 1'b1;
        byte_out   = data_reg[15:8];
      end
      B2: begin
        pix_ready  = 1'b1;
        byte_valid = 1'b1;
        byte_out   = data_reg[23:16];
      end
      default: ;
    endcase
`ifdef TEST_PATTERN_EN
    if (test_mode) pix_ready = 1'b0;
`endif
  end

  frame_pos_counter #(
    .H_PIXELS (H_PIXELS),
    .V_LINES  (V_LINES),
    .CW       (CW)
  ) u_pos (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .sof        (load_sof),
    .last_byte  (state == B2),
    .px_out     (px_out),
    .line_out   (line_out),
`ifdef TEST_PATTERN_EN
    .next_px    (next_px),
`endif
    .frame_done (frame_done),
    .sof_err    (sof_err)
  );

endmodule

// File: tb/tb_frame_byte_serializer.sv
// Self-checking bench for frame_byte_serializer. A transaction-level model
// turns each accepted pixel into three expected byte records and keeps the
// raster position with plain arithmetic; each scenario task compares the DUT
// against it cycle by cycle plus scenario-specific constants.
module tb_frame_byte_serializer;

  localparam int H = 110;
  localparam int V = 110;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_valid;
  logic        pix_ready;
  logic [23:0] pix_data;
  logic        pix_sof;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic [9:0]  px_out;
  logic [9:0]  line_out;
  logic        frame_done;
  logic        sof_err;
`ifdef TEST_PATTERN_EN
  logic        test_mode;
`endif

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] b;
    int         px;
    int         ln;
    bit         fd;
    bit         se;
  } rec_t;

  rec_t q[$];
  rec_t exp_r;
  bit   exp_valid;
  bit   exp_ready;
  int   mx;
  int   my;

  frame_byte_serializer dut (
    .clk        (clk),
    .reset      (reset),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_sof    (pix_sof),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .px_out     (px_out),
    .line_out   (line_out),
    .frame_done (frame_done),
    .sof_err    (sof_err)
`ifdef TEST_PATTERN_EN
    ,
    .test_mode  (test_mode)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    mx        = 0;
    my        = 0;
    exp_valid = 1'b0;
    exp_ready = 1'b1;
  endtask

  task automatic model_accept(input logic [23:0] d, input bit s);
    int   cx;
    int   cy;
    bit   err;
    rec_t r;
    err = s && (mx != 0 || my != 0);
    cx  = s ? 0 : mx;
    cy  = s ? 0 : my;
    for (int k = 0; k < 3; k++) begin
      r.b  = d[8*k +: 8];
      r.px = cx;
      r.ln = cy;
      r.fd = (k == 2) && (cx == H - 1) && (cy == V - 1);
      r.se = (k == 0) && err;
      q.push_back(r);
    end
    mx = cx + 1;
    my = cy;
    if (mx == H) begin
      mx = 0;
      my = cy + 1;
      if (my == V) my = 0;
    end
  endtask

  task automatic drive_cycle(input bit v, input logic [23:0] d, input bit s, output bit acc);
    bit had;
    had       = exp_valid;
    pix_valid = v;
    pix_data  = d;
    pix_sof   = s;
    acc       = v && exp_ready;
    if (acc) model_accept(d, s);
    @(posedge clk);
    #1;
    if (had) void'(q.pop_front());
    exp_valid = (q.size() > 0);
    if (exp_valid) exp_r = q[0];
    exp_ready = (q.size() <= 1);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_data  = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [31:0] obs[7];
    logic [31:0] req[7];
    string       nm[7];
    do_reset();
    obs = '{32'(pix_ready), 32'(byte_valid), 32'(byte_out), 32'(px_out),
            32'(line_out), 32'(frame_done), 32'(sof_err)};
    req = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    nm  = '{"pix_ready", "byte_valid", "byte_out", "px_out", "line_out", "frame_done", "sof_err"};
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (obs[i] !== req[i]) begin
        n_err++;
        $display("[TB] FAIL reset_%s: got %0h required %0h", nm[i], obs[i], req[i]);
      end
    end
  endtask

  task automatic test_single_pixel();
    logic [7:0] want[3];
    bit acc;
    want = '{8'h11, 8'h22, 8'h33};
    do_reset();
    drive_cycle(1'b1, 24'h332211, 1'b1, acc);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (byte_valid !== 1'b1 || byte_out !== want[k] || px_out !== 10'd0 ||
          line_out !== 10'd0 || sof_err !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL single_byte%0d: got v=%b byte=%h px=%0d ln=%0d se=%b required v=1 byte=%h px=0 ln=0 se=0",
                 k, byte_valid, byte_out, px_out, line_out, sof_err, want[k]);
      end
      drive_cycle(1'b0, 24'h0, 1'b0, acc);
    end
    n_cmp++;
    if (byte_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL single_idle: got byte_valid=%b required 0", byte_valid);
    end
  endtask

  task automatic test_stream();
    int accepted = 0;
    int mv = 0;
    int dv = 0;
    int run = 0;
    int max_run = 0;
    bit acc;
    do_reset();
    for (int cyc = 0; cyc < 340; cyc++) begin
      drive_cycle(accepted < 111, 24'($urandom()), accepted == 0, acc);
      if (acc) accepted++;
      if (exp_valid) mv++;
      if (byte_valid === 1'b1) begin
        dv++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      n_cmp++;
      if (pix_ready !== exp_ready || byte_valid !== exp_valid ||
          (exp_valid && (byte_out !== exp_r.b || px_out !== 10'(exp_r.px) || line_out !== 10'(exp_r.ln))) ||
          frame_done !== (exp_valid && exp_r.fd) || sof_err !== (exp_valid && exp_r.se)) begin
        n_err++;
        $display("[TB] FAIL stream_cycle %0d: got rdy=%b v=%b byte=%h px=%0d ln=%0d fd=%b se=%b required rdy=%b v=%b byte=%h px=%0d ln=%0d fd=%b se=%b",
                 cyc, pix_ready, byte_valid, byte_out, px_out, line_out, frame_done, sof_err,
                 exp_ready, exp_valid, exp_r.b, exp_r.px, exp_r.ln, exp_r.fd, exp_r.se);
      end
      if (exp_valid && mv == 331) begin
        n_cmp++;
        if (px_out !== 10'd0 || line_out !== 10'd1) begin
          n_err++;
          $display("[TB] FAIL stream_pixel110_pos: got px=%0d ln=%0d required px=0 ln=1", px_out, line_out);
        end
      end
    end
    n_cmp++;
    if (dv !== 333 || max_run !== 333) begin
      n_err++;
      $display("[TB] FAIL stream_contiguous: got %0d valid cycles, longest run %0d, required 333 and 333", dv, max_run);
    end
  endtask

  task automatic test_full_frame();
    int accepted = 0;
    int mv = 0;
    int fd_count = 0;
    bit acc;
    do_reset();
    for (int cyc = 0; cyc < 36310; cyc++) begin
      drive_cycle(accepted < H * V + 1, 24'($urandom()), accepted == 0, acc);
      if (acc) accepted++;
      if (exp_valid) mv++;
      n_cmp++;
      if (pix_ready !== exp_ready || byte_valid !== exp_valid ||
          (exp_valid && (byte_out !== exp_r.b || px_out !== 10'(exp_r.px) || line_out !== 10'(exp_r.ln))) ||
          frame_done !== (exp_valid && exp_r.fd) || sof_err !== (exp_valid && exp_r.se)) begin
        n_err++;
        $display("[TB] FAIL frame_cycle %0d: got v=%b byte=%h px=%0d ln=%0d fd=%b se=%b required v=%b byte=%h px=%0d ln=%0d fd=%b se=%b",
                 cyc, byte_valid, byte_out, px_out, line_out, frame_done, sof_err,
                 exp_valid, exp_r.b, exp_r.px, exp_r.ln, exp_r.fd, exp_r.se);
      end
      if (frame_done === 1'b1) begin
        fd_count++;
        n_cmp++;
        if (mv !== H * V * 3 || px_out !== 10'd109 || line_out !== 10'd109) begin
          n_err++;
          $display("[TB] FAIL frame_done_position: got byte#%0d px=%0d ln=%0d required byte#%0d px=109 ln=109",
                   mv, px_out, line_out, H * V * 3);
        end
      end
      if (exp_valid && mv == H * V * 3 + 1) begin
        n_cmp++;
        if (px_out !== 10'd0 || line_out !== 10'd0) begin
          n_err++;
          $display("[TB] FAIL frame_next_pixel: got px=%0d ln=%0d required px=0 ln=0", px_out, line_out);
        end
      end
    end
    n_cmp++;
    if (fd_count !== 1) begin
      n_err++;
      $display("[TB] FAIL frame_done_count: got %0d required 1", fd_count);
    end
  endtask

  task automatic test_sof_midframe();
    int accepted = 0;
    int mv = 0;
    int se_count = 0;
    bit acc;
    do_reset();
    for (int cyc = 0; cyc < 700; cyc++) begin
      drive_cycle(accepted < 228, 24'($urandom()), accepted == 0 || accepted == 225, acc);
      if (acc) accepted++;
      if (exp_valid) mv++;
      if (sof_err === 1'b1) se_count++;
      n_cmp++;
      if (byte_valid !== exp_valid ||
          (exp_valid && (byte_out !== exp_r.b || px_out !== 10'(exp_r.px) || line_out !== 10'(exp_r.ln))) ||
          sof_err !== (exp_valid && exp_r.se)) begin
        n_err++;
        $display("[TB] FAIL sof_cycle %0d: got v=%b byte=%h px=%0d ln=%0d se=%b required v=%b byte=%h px=%0d ln=%0d se=%b",
                 cyc, byte_valid, byte_out, px_out, line_out, sof_err,
                 exp_valid, exp_r.b, exp_r.px, exp_r.ln, exp_r.se);
      end
      if (exp_valid && mv == 676) begin
        n_cmp++;
        if (sof_err !== 1'b1 || px_out !== 10'd0 || line_out !== 10'd0) begin
          n_err++;
          $display("[TB] FAIL sof_forced_pixel: got se=%b px=%0d ln=%0d required se=1 px=0 ln=0",
                   sof_err, px_out, line_out);
        end
      end
    end
    n_cmp++;
    if (se_count !== 1) begin
      n_err++;
      $display("[TB] FAIL sof_err_count: got %0d required 1", se_count);
    end
  endtask

  task automatic test_reset_mid_pixel();
    int accepted = 0;
    int mv = 0;
    bit acc;
    do_reset();
    while (mv < 11 && accepted < 10) begin
      drive_cycle(accepted < 4, 24'($urandom()), 1'b0, acc);
      if (acc) accepted++;
      if (exp_valid) mv++;
    end
    n_cmp++;
    if (byte_valid !== 1'b1 || byte_out !== exp_r.b || px_out !== 10'd3) begin
      n_err++;
      $display("[TB] FAIL midreset_before: got v=%b byte=%h px=%0d required v=1 byte=%h px=3",
               byte_valid, byte_out, px_out, exp_r.b);
    end
    reset     = 1'b1;
    pix_valid = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (byte_valid !== 1'b0 || px_out !== 10'd0 || line_out !== 10'd0 || pix_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL midreset_after: got v=%b px=%0d ln=%0d rdy=%b required v=0 px=0 ln=0 rdy=1",
               byte_valid, px_out, line_out, pix_ready);
    end
    reset = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < 6; cyc++) begin
      drive_cycle(cyc == 0, 24'hA5C3E1, 1'b0, acc);
      n_cmp++;
      if (byte_valid !== exp_valid ||
          (exp_valid && (byte_out !== exp_r.b || px_out !== 10'(exp_r.px) || line_out !== 10'(exp_r.ln))) ||
          sof_err !== (exp_valid && exp_r.se)) begin
        n_err++;
        $display("[TB] FAIL midreset_resume %0d: got v=%b byte=%h px=%0d ln=%0d se=%b required v=%b byte=%h px=%0d ln=%0d se=%b",
                 cyc, byte_valid, byte_out, px_out, line_out, sof_err,
                 exp_valid, exp_r.b, exp_r.px, exp_r.ln, exp_r.se);
      end
    end
  endtask

  task automatic test_random_gaps();
    bit acc;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      drive_cycle(1'($urandom_range(0, 1)), 24'($urandom()), $urandom_range(0, 15) == 0, acc);
      n_cmp++;
      if (pix_ready !== exp_ready || byte_valid !== exp_valid ||
          (exp_valid && (byte_out !== exp_r.b || px_out !== 10'(exp_r.px) || line_out !== 10'(exp_r.ln))) ||
          frame_done !== (exp_valid && exp_r.fd) || sof_err !== (exp_valid && exp_r.se)) begin
        n_err++;
        $display("[TB] FAIL gaps_cycle %0d: got rdy=%b v=%b byte=%h px=%0d ln=%0d se=%b required rdy=%b v=%b byte=%h px=%0d ln=%0d se=%b",
                 cyc, pix_ready, byte_valid, byte_out, px_out, line_out, sof_err,
                 exp_ready, exp_valid, exp_r.b, exp_r.px, exp_r.ln, exp_r.se);
      end
    end
  endtask

`ifdef TEST_PATTERN_EN
  task automatic test_pattern();
    int          nbytes = 0;
    int          pixel = 0;
    int          px;
    int          bar;
    logic [23:0] asm_px;
    logic [23:0] want;
    do_reset();
    test_mode = 1'b1;
    pix_valid = 1'b1;
    for (int cyc = 0; cyc < 336; cyc++) begin
      pix_data = 24'($urandom());
      @(posedge clk);
      #1;
      n_cmp++;
      if (pix_ready !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL pattern_ready cycle %0d: got %b required 0", cyc, pix_ready);
      end
      if (byte_valid === 1'b1) begin
        asm_px[8*(nbytes % 3) +: 8] = byte_out;
        nbytes++;
        if (nbytes % 3 == 0) begin
          px   = pixel % H;
          bar  = (px * 8) / H;
          want = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
          n_cmp++;
          if (asm_px !== want || px_out !== 10'(px)) begin
            n_err++;
            $display("[TB] FAIL pattern_pixel %0d: got %h at px=%0d required %h at px=%0d",
                     pixel, asm_px, px_out, want, px);
          end
          if (px == 0 || px == 14 || px == 109) begin
            want = (px == 0) ? 24'h000000 : (px == 14) ? 24'h0000FF : 24'hFFFFFF;
            n_cmp++;
            if (asm_px !== want) begin
              n_err++;
              $display("[TB] FAIL pattern_px%0d: got %h required %h", px, asm_px, want);
            end
          end
          pixel++;
        end
      end
    end
    n_cmp++;
    if (nbytes !== 336) begin
      n_err++;
      $display("[TB] FAIL pattern_byte_count: got %0d required 336", nbytes);
    end
    test_mode = 1'b0;
    do_reset();
  endtask
`endif

  initial begin
    reset     = 1'b1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_data  = '0;
`ifdef TEST_PATTERN_EN
    test_mode = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_pixel();
    test_stream();
    test_sof_midframe();
    test_reset_mid_pixel();
    test_random_gaps();
    test_full_frame();
`ifdef TEST_PATTERN_EN
    test_pattern();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
